// File: rtl/vd_ber_monitor.sv
// Viterbi decoder BER monitor: windowed bit-error counter against delayed reference.
// Optional window alarm is enabled by defining VDMON_ALARM_EN.
module vd_ber_monitor #(
  parameter int DEC_LAT  = 15,
  parameter int WIN_LOG2 = 10,
  parameter int CNT_W    = 16,
  parameter int ALARM_TH = 64
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic             Active,
  input  logic             RefBit,
  input  logic             DecodeOut,
  input  logic             Clear,
  output logic [CNT_W-1:0] ErrCount,
  output logic [15:0]      WinCount,
  output logic             WinDone,
  output logic             Filled,
  output logic             Alarm
);

  localparam int FW = $clog2(DEC_LAT + 1);
  localparam int BW = WIN_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    MEAS
  } state_t;

  state_t             state_q;
  logic [DEC_LAT-1:0] dl_q;
  logic [DEC_LAT-1:0] dl_d;
  logic [FW-1:0]      fill_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   err_d;
  logic [BW-1:0]      bit_q;
  logic [CNT_W-1:0]   errcnt_q;
  logic [15:0]        win_q;
  logic               done_q;
  logic               filled_q;
  logic               ref_bit;
  logic               cmp;
  logic               win_end;

  if (DEC_LAT == 1) begin : g_dl1
    assign dl_d = RefBit;
  end else begin : g_dln
    assign dl_d = {dl_q[DEC_LAT-2:0], RefBit};
  end

  assign ref_bit = dl_q[DEC_LAT-1];

  // The FILL bit with fill_q==DEC_LAT already has a valid reference.
  always_comb begin
    cmp = Active &&
          (state_q == MEAS ||
           (state_q == FILL && fill_q == FW'(DEC_LAT)));
    err_d = (&err_q) ? err_q :
            err_q + CNT_W'(DecodeOut ^ ref_bit);
    win_end = cmp &&
              bit_q == BW'((1 << WIN_LOG2) - 1);
  end

`ifdef VDMON_ALARM_EN
  logic alarm_q;
  assign Alarm = alarm_q;
`else
  assign Alarm = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (!Reset || Clear) begin
      state_q  <= IDLE;
      dl_q     <= '0;
      fill_q   <= '0;
      err_q    <= '0;
      bit_q    <= '0;
      errcnt_q <= '0;
      win_q    <= '0;
      done_q   <= 1'b0;
      filled_q <= 1'b0;
`ifdef VDMON_ALARM_EN
      alarm_q  <= 1'b0;
`endif
    end else begin
      done_q <= win_end;
      if (Active) begin
        dl_q <= dl_d;
        unique case (state_q)
          IDLE: begin
            state_q <= FILL;
            fill_q  <= FW'(1);
          end
          FILL: begin
            if (fill_q == FW'(DEC_LAT)) begin
              state_q  <= MEAS;
              filled_q <= 1'b1;
            end else begin
              fill_q <= fill_q + FW'(1);
            end
          end
          MEAS: ;
          default: state_q <= IDLE;
        endcase
        if (cmp) begin
          if (win_end) begin
            errcnt_q <= err_d;
            win_q    <= win_q + 16'd1;
            err_q    <= '0;
            bit_q    <= '0;
`ifdef VDMON_ALARM_EN
            alarm_q  <= (err_d >= CNT_W'(ALARM_TH));
`endif
          end else begin
            err_q <= err_d;
            bit_q <= bit_q + BW'(1);
          end
        end
      end
    end
  end

  assign ErrCount = errcnt_q;
  assign WinCount = win_q;
  assign WinDone  = done_q;
  assign Filled   = filled_q;

endmodule
